// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory burst arbiter: default widths,
// arbiter state encoding and requester indices.
package dmem_pkg;

    localparam int DMEM_AW = 16;
    localparam int DMEM_DW = 16;
    localparam int DMEM_LW = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to the
// requester named by rr_ptr_i. Purely combinational, one-hot (or zero) result.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       rr_ptr_i,
    output logic [1:0] gnt_o
);

    // Winner selection
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = rr_ptr_i ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin burst arbiter sharing one 16-bit data-memory port between the
// CPU load/store stage (requester 0) and the DMA/debug loader (requester 1).
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int AW = DMEM_AW,
    parameter int DW = DMEM_DW,
    parameter int LW = DMEM_LW
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [LW-1:0] m0_len,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_ack,
    output logic          m0_last,
    output logic [DW-1:0] m0_rdata,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [LW-1:0] m1_len,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_ack,
    output logic          m1_last,
    output logic [DW-1:0] m1_rdata,

    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);

    state_e        state_q,  state_d;
    logic          owner_q,  owner_d;
    logic          we_q,     we_d;
    logic          rr_ptr_q, rr_ptr_d;
    logic [AW-1:0] addr_q,   addr_d;
    logic [LW-1:0] beat_q,   beat_d;

    logic [1:0]    win_s;
    logic          busy_s;
    logic          final_s;

    rr_arb2 u_rr_arb2 (
        .req_i    ({m1_req, m0_req}),
        .rr_ptr_i (rr_ptr_q),
        .gnt_o    (win_s)
    );

    assign busy_s  = (state_q == ST_BURST);
    assign final_s = busy_s && (beat_q == {LW{1'b0}});

    // Next-state: grant latch in IDLE, address/beat stepping in BURST
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        rr_ptr_d = rr_ptr_q;
        addr_d   = addr_q;
        beat_d   = beat_q;
        case (state_q)
            ST_IDLE: begin
                if (|win_s) begin
                    state_d = ST_BURST;
                    owner_d = win_s[REQ_DMA];
                    if (win_s[REQ_DMA]) begin
                        we_d   = m1_we;
                        addr_d = m1_addr;
                        beat_d = m1_len;
                    end else begin
                        we_d   = m0_we;
                        addr_d = m0_addr;
                        beat_d = m0_len;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BURST: begin
                // The address holds on the final beat so mem_addr keeps its
                // last driven value while the port is idle.
                if (final_s) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = ~owner_q;
                end else begin
                    addr_d = addr_q + AW'(1);
                    beat_d = beat_q - LW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Arbiter state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            owner_q  <= REQ_CPU;
            we_q     <= 1'b0;
            rr_ptr_q <= REQ_CPU;
            addr_q   <= {AW{1'b0}};
            beat_q   <= {LW{1'b0}};
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            rr_ptr_q <= rr_ptr_d;
            addr_q   <= addr_d;
            beat_q   <= beat_d;
        end
    end

    // Port drive and return path; only wdata and rdata pass through combinationally
    always_comb begin
        mem_addr  = addr_q;
        mem_we    = busy_s && we_q;
        mem_wdata = {DW{1'b0}};
        m0_gnt    = 1'b0;
        m0_last   = 1'b0;
        m0_rdata  = {DW{1'b0}};
        m1_gnt    = 1'b0;
        m1_last   = 1'b0;
        m1_rdata  = {DW{1'b0}};
        if (busy_s) begin
            if (owner_q == REQ_DMA) begin
                mem_wdata = m1_wdata;
                m1_gnt    = 1'b1;
                m1_last   = final_s;
                m1_rdata  = mem_rdata;
            end else begin
                mem_wdata = m0_wdata;
                m0_gnt    = 1'b1;
                m0_last   = final_s;
                m0_rdata  = mem_rdata;
            end
        end else begin
            mem_wdata = {DW{1'b0}};
        end
    end

    assign m0_ack = m0_gnt;
    assign m1_ack = m1_gnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a transaction-level model predicts every
// beat (owner, address, data, last) and a negedge monitor checks the DUT.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [15:0] m0_addr = 16'h0, m1_addr = 16'h0, m0_wdata = 16'h0, m1_wdata = 16'h0;
    logic [3:0]  m0_len = 4'h0, m1_len = 4'h0;
    logic        m0_gnt, m0_ack, m0_last, m1_gnt, m1_ack, m1_last, mem_we;
    logic [15:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;

    logic [15:0] mem     [65536];
    logic [15:0] ref_mem [65536];

    typedef struct {
        logic        owner;
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
        logic        last;
    } beat_t;

    beat_t sb[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    logic  pref     = 1'b0;

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_len(m0_len),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_last(m0_last),
        .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_len(m1_len),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_last(m1_last),
        .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory: combinational read, write committed on the falling edge
    assign mem_rdata = mem[mem_addr];
    always @(negedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model: the burst's beats in order; reads see every earlier predicted write
    task automatic push_burst(input logic idx, input logic we, input logic [15:0] addr,
                              input logic [3:0] len, input logic [15:0] wd [16], input int nbeats);
        beat_t e;
        for (int i = 0; i < nbeats; i++) begin
            e.owner = idx;
            e.we    = we;
            e.addr  = addr + 16'(i);
            e.last  = (i == int'(len));
            if (we) begin
                e.data = wd[i];
                ref_mem[e.addr] = wd[i];
            end else begin
                e.data = ref_mem[e.addr];
            end
            sb.push_back(e);
        end
        pref = ~idx;
    endtask

    function automatic logic gnt_of(input logic idx);
        return idx ? m1_gnt : m0_gnt;
    endfunction

    task automatic set_req(input logic idx, input logic r, input logic we,
                           input logic [15:0] addr, input logic [3:0] len);
        if (idx) begin m1_req = r; m1_we = we; m1_addr = addr; m1_len = len; end
        else     begin m0_req = r; m0_we = we; m0_addr = addr; m0_len = len; end
    endtask

    task automatic set_wdata(input logic idx, input logic [15:0] d);
        if (idx) m1_wdata = d; else m0_wdata = d;
    endtask

    // Requester: raise req, drop it after the grant, feed one wdata per ack cycle
    task automatic run_req(input logic idx, input logic we, input logic [15:0] addr,
                           input logic [3:0] len, input logic [15:0] wd [16], input int exp_wait);
        int waited = 0;
        set_req(idx, 1'b1, we, addr, len);
        do begin
            @(posedge clk); #1;
            waited++;
        end while (!gnt_of(idx) && waited < 100);
        chk($sformatf("gnt_timeout_m%0d", idx), gnt_of(idx), 1);
        if (!gnt_of(idx)) begin
            set_req(idx, 1'b0, we, addr, len);
            return;
        end
        if (exp_wait >= 0) chk($sformatf("gnt_latency_m%0d", idx), waited, exp_wait);
        set_req(idx, 1'b0, ~we, 16'($urandom), 4'($urandom));
        for (int b = 0; b <= int'(len); b++) begin
            if (b > 0) begin @(posedge clk); #1; end
            set_wdata(idx, wd[b]);
        end
    endtask

    task automatic idle_gap();
        @(posedge clk); #1;
    endtask

    task automatic single(input logic idx, input logic we, input logic [15:0] addr,
                          input logic [3:0] len, input logic [15:0] wd [16]);
        push_burst(idx, we, addr, len, wd, int'(len) + 1);
        run_req(idx, we, addr, len, wd, 1);
        idle_gap();
    endtask

    task automatic both(input logic we0, input logic [15:0] a0, input logic [3:0] l0,
                        input logic [15:0] w0 [16], input logic we1, input logic [15:0] a1,
                        input logic [3:0] l1, input logic [15:0] w1 [16]);
        int e0, e1;
        if (pref == 1'b0) begin
            e0 = 1; e1 = int'(l0) + 3;
            push_burst(1'b0, we0, a0, l0, w0, int'(l0) + 1);
            push_burst(1'b1, we1, a1, l1, w1, int'(l1) + 1);
        end else begin
            e1 = 1; e0 = int'(l1) + 3;
            push_burst(1'b1, we1, a1, l1, w1, int'(l1) + 1);
            push_burst(1'b0, we0, a0, l0, w0, int'(l0) + 1);
        end
        fork
            run_req(1'b0, we0, a0, l0, w0, e0);
            run_req(1'b1, we1, a1, l1, w1, e1);
        join
        idle_gap();
    endtask

    // Monitor: every ack cycle must match the head of the scoreboard
    logic  prev_last = 1'b0;
    logic  own;
    beat_t got;
    always @(negedge clk) begin
        if (!reset) begin
            prev_last = 1'b0;
        end else if (m0_ack || m1_ack) begin
            own = m1_ack;
            chk("single_owner", m0_ack & m1_ack, 0);
            if (prev_last) chk("idle_gap", m0_ack | m1_ack, 0);
            if (sb.size() == 0) begin
                chk("unexpected_beat", m0_ack | m1_ack, 0);
            end else begin
                got = sb.pop_front();
                chk("owner", own, got.owner);
                chk("mem_addr", mem_addr, got.addr);
                chk("mem_we", mem_we, got.we);
                chk("gnt", own ? m1_gnt : m0_gnt, 1);
                chk("last", own ? m1_last : m0_last, got.last);
                chk("other_quiet", own ? {m0_gnt, m0_ack, m0_last, |m0_rdata}
                                       : {m1_gnt, m1_ack, m1_last, |m1_rdata}, 0);
                if (got.we) chk("mem_wdata", mem_wdata, got.data);
                else        chk("rdata", own ? m1_rdata : m0_rdata, got.data);
            end
            prev_last = own ? m1_last : m0_last;
        end else begin
            chk("idle_quiet", {mem_we, m0_gnt, m1_gnt, m0_last, m1_last}, 0);
            prev_last = 1'b0;
        end
    end

    initial begin
        logic [15:0] wa [16];
        logic [15:0] wb [16];
        int          waited;
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 16'(i);
            ref_mem[i] = 16'(i);
        end
        for (int i = 0; i < 16; i++) begin wa[i] = 16'h0; wb[i] = 16'h0; end

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {mem_we, m0_gnt, m0_ack, m0_last, m1_gnt, m1_ack, m1_last}, 0);
        chk("reset_mem_addr", mem_addr, 0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        // Directed: read, write-then-readback, wrap
        single(1'b0, 1'b0, 16'h0010, 4'd3, wa);
        wa[0] = 16'hBEEF; wa[1] = 16'hCAFE;
        single(1'b1, 1'b1, 16'h0100, 4'd1, wa);
        single(1'b0, 1'b0, 16'h0100, 4'd1, wa);
        single(1'b0, 1'b0, 16'hFFFE, 4'd3, wa);
        single(1'b0, 1'b0, 16'h0020, 4'd2, wa);

        // Fairness: both asking with single-beat bursts
        for (int r = 0; r < 3; r++) both(1'b0, 16'h0030, 4'd0, wa, 1'b0, 16'h0040, 4'd0, wb);

        // Reset in the middle of an m1 write burst: only beats 0 and 1 land
        for (int i = 0; i < 16; i++) wa[i] = 16'($urandom);
        push_burst(1'b1, 1'b1, 16'h0200, 4'd7, wa, 2);
        set_req(1'b1, 1'b1, 1'b1, 16'h0200, 4'd7);
        waited = 0;
        do begin @(posedge clk); #1; waited++; end while (!m1_gnt && waited < 100);
        chk("rst_test_gnt", m1_gnt, 1);
        set_wdata(1'b1, wa[0]);
        set_req(1'b1, 1'b0, 1'b0, 16'h0, 4'd0);
        @(posedge clk); #1; set_wdata(1'b1, wa[1]);
        @(posedge clk); #1;
        chk("rst_beat2_live", m1_ack, 1);
        reset = 1'b0;
        #1;
        chk("rst_drop", {mem_we, m0_gnt, m0_ack, m1_gnt, m1_ack, m1_last}, 0);
        pref = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        both(1'b0, 16'h0200, 4'd7, wa, 1'b0, 16'h0050, 4'd0, wb);

        // Randomized mix of lone and contended bursts
        for (int it = 0; it < 40; it++) begin
            logic [15:0] ra0, ra1;
            logic [3:0]  rl0, rl1;
            logic        rw0, rw1;
            int          mode;
            for (int i = 0; i < 16; i++) begin wa[i] = 16'($urandom); wb[i] = 16'($urandom); end
            ra0 = ($urandom_range(0, 3) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15)) : 16'($urandom);
            ra1 = ($urandom_range(0, 3) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15)) : 16'($urandom);
            rl0 = 4'($urandom); rl1 = 4'($urandom);
            rw0 = 1'($urandom); rw1 = 1'($urandom);
            mode = $urandom_range(0, 2);
            if (mode == 0)      single(1'b0, rw0, ra0, rl0, wa);
            else if (mode == 1) single(1'b1, rw1, ra1, rl1, wb);
            else                both(rw0, ra0, rl0, wa, rw1, ra1, rl1, wb);
        end

        waited = 0;
        while (sb.size() != 0 && waited < 50) begin @(posedge clk); waited++; end
        #1;
        chk("sb_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester burst arbiter in front of the 16-bit data memory. It shares the single memory port between requester 0 (CPU load/store stage) and requester 1 (DMA/debug loader), using round-robin arbitration. Each grant covers a burst of 1..16 consecutive words. It drives the memory's address, write-data and write-enable, and returns the memory's combinational read data to the owning requester.

Parameters:
AW, 16, address width (word address)
DW, 16, data width
LW, 4, burst-length field width; field value n means n+1 beats

Ports:
clk  in  1  system clock; all state updates on posedge
reset  in  1  asynchronous, active-low reset
m0_req  in  1  requester 0 access request
m0_we  in  1  requester 0 write (1) / read (0); sampled at grant
m0_addr  in  AW  requester 0 start word address; sampled at grant
m0_len  in  LW  requester 0 beats minus one; sampled at grant
m0_wdata  in  DW  requester 0 write data for the current beat
m0_gnt  out  1  requester 0 owns the port (BURST state)
m0_ack  out  1  beat completes this cycle
m0_last  out  1  final beat of burst (qualified by m0_ack)
m0_rdata  out  DW  read data, valid when m0_ack && !we
m1_*  (same set as m0_*)  requester 1
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_we  out  1  memory write enable
mem_rdata  in  DW  memory combinational read data

Behaviour:
- Reset (reset low, async): state=IDLE, mem_we=0, mem_addr=0, gnt/ack/last=0 for both, rr_ptr=0 (requester 0 preferred). Any burst in flight is aborted silently; the requester gets no last beat.
- States: IDLE, BURST.
- IDLE, posedge, any req high: winner = the only requester asking, or, if both ask, the one rr_ptr points to. Latch owner, we, addr into cur_addr, and len into beat_cnt. Go to BURST. No request: stay in IDLE.
- BURST, every cycle:
  - mem_addr=cur_addr (registered).
  - mem_we=latched we.
  - mem_wdata=owner's wdata, combinational mux.
  - owner gnt=1 and ack=1; owner rdata=mem_rdata, combinational.
  - Non-owner outputs are 0.
  - Memory commits writes on the following negedge, so mem_we/addr/wdata are stable for the whole high phase.
- BURST, posedge: cur_addr += 1 mod 2^AW (0xFFFF wraps to 0x0000), beat_cnt -= 1.
- Last beat (beat_cnt==0): last=1 alongside ack. Next state is IDLE and rr_ptr is set to the non-owner.
- Latency: req sampled at edge k, first ack at cycle k+1. Burst of n+1 beats occupies cycles k+1..k+n+1. One mandatory IDLE cycle between bursts, so back-to-back throughput is (n+1)/(n+2).
- Requester must present wdata for beat i during its i-th ack cycle. Changing we/addr/len after grant has no effect. Dropping req mid-burst is ignored: the burst runs to completion.
- Outside BURST: mem_we=0 and mem_addr holds its last value.
- Fairness: with both requesters continuously asking, grants strictly alternate.
- No combinational path from req to mem_* signals. Only wdata→mem_wdata and mem_rdata→rdata are combinational.

Decomposition:
- Shared package dmem_pkg:
  - AW/DW/LW defaults
  - state encoding constants ST_IDLE/ST_BURST
  - requester index constants REQ_CPU=0, REQ_DMA=1
- One sub-module, rr_arb2: 2-way round-robin pick from {req, rr_ptr} to a one-hot winner. Purely combinational.
- Burst counter, address register and muxes live in the top module.

Test Plan:
- Memory holds its reset image (mem[i]=i). m0 read, addr=0x0010, len=3 → acks at cycles 1..4 with rdata 0x0010..0x0013, m0_last on the 4th ack, mem_we=0 throughout.
- m1 write, addr=0x0100, len=1, wdata 0xBEEF then 0xCAFE → then an m0 read of 0x0100 with len=1 returns 0xBEEF, 0xCAFE.
- Both req high continuously, len=0 each, from reset → grants go m0, m1, m0, m1 with one IDLE cycle between each; never the same requester twice in a row.
- Wrap: m0 read, addr=0xFFFE, len=3 → mem_addr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001, with rdata equal to those values.
- Reset pulsed low during beat 2 of an m1 write, addr=0x0200, len=7 → mem_we and all gnt/ack drop immediately. After release, state is IDLE with m0 preferred. Words 0x0202..0x0207 are unchanged.
- m0 drops req after its first ack, len=2 → all 3 beats still occur and m0_last is asserted.
